// File: rtl/host_line_responder_if.sv
// Word-wide request/acknowledge backing-memory port used by host_line_responder.
interface host_line_responder_if #(
    parameter int unsigned WORD_BITS = 32
) ();
    logic                 mem_req;
    logic                 mem_wr;
    logic [31:0]          mem_addr;
    logic [WORD_BITS-1:0] mem_wdata;
    logic                 mem_ack;
    logic [WORD_BITS-1:0] mem_rdata;

    modport master (
        output mem_req, mem_wr, mem_addr, mem_wdata,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_wr, mem_addr, mem_wdata,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/host_line_responder.sv
// Host line responder: serialises one 512-bit line request into 16 word beats on a req/ack memory port.
// Optional per-beat acknowledge timeout with err_host: define HOST_RESP_TIMEOUT_EN.
module host_line_responder #(
    parameter int unsigned LINE_BITS      = 512,
    parameter int unsigned WORD_BITS      = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [1:0]            op_host,
    input  logic [31:0]           AddrOut_host,
    input  logic [LINE_BITS-1:0]  DataOut_host,
    output logic [LINE_BITS-1:0]  DataIn_host,
    output logic                  rd_valid_host,
    output logic                  tx_done_host,
`ifdef HOST_RESP_TIMEOUT_EN
    output logic                  err_host,
`endif
    host_line_responder_if.master mem
);
    localparam int unsigned BEATS      = LINE_BITS / WORD_BITS;
    localparam int unsigned BEAT_W     = $clog2(BEATS);
    localparam int unsigned WORD_BYTES = WORD_BITS / 8;
    localparam logic [1:0]  OP_NONE    = 2'b00;
    localparam logic [1:0]  OP_RD      = 2'b01;
    localparam logic [1:0]  OP_WR      = 2'b10;

    typedef enum logic [1:0] {S_IDLE, S_BEAT, S_DONE} state_t;

    state_t                r_state;
    state_t                w_next;
    logic                  w_accept;
    logic                  w_last;
    logic                  r_armed;
    logic                  r_req;
    logic                  r_wr;
    logic [31:0]           r_addr;
    logic [BEAT_W-1:0]     r_beat;
    logic [LINE_BITS-1:0]  r_wline;
    logic [LINE_BITS-1:0]  r_rdata;
    logic                  r_rd_valid;
    logic                  r_tx_done;
    logic                  w_unused_addr;

    assign w_unused_addr = ^AddrOut_host[5:0];

`ifdef HOST_RESP_TIMEOUT_EN
    localparam int unsigned WAIT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WAIT_W-1:0] r_wait;
    logic              r_err;
    logic              w_timeout;

    // Wait counter restarts on every ack and outside the beat state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wait <= '0;
            r_err  <= 1'b0;
        end else begin
            r_err <= w_timeout;
            if (r_state != S_BEAT || mem.mem_ack) begin
                r_wait <= '0;
            end else begin
                r_wait <= r_wait + WAIT_W'(1);
            end
        end
    end

    assign err_host = r_err;
`else
    logic w_unused_param;
    assign w_unused_param = 1'(TIMEOUT_CYCLES);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        w_last   = 1'b0;
`ifdef HOST_RESP_TIMEOUT_EN
        w_timeout = 1'b0;
`endif
        case (r_state)
            S_IDLE: begin
                if (r_armed && (op_host == OP_RD || op_host == OP_WR)) begin
                    w_accept = 1'b1;
                    w_next   = S_BEAT;
                end
            end
            S_BEAT: begin
                if (mem.mem_ack) begin
                    if (r_beat == BEAT_W'(BEATS - 1)) begin
                        w_last = 1'b1;
                        w_next = S_DONE;
                    end
                end
`ifdef HOST_RESP_TIMEOUT_EN
                else if (r_wait == WAIT_W'(TIMEOUT_CYCLES - 1)) begin
                    w_timeout = 1'b1;
                    w_next    = S_DONE;
                end
`endif
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Beat datapath; r_wline shifts so the current write word always sits in the low slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_armed    <= 1'b1;
            r_req      <= 1'b0;
            r_wr       <= 1'b0;
            r_addr     <= '0;
            r_beat     <= '0;
            r_wline    <= '0;
            r_rdata    <= '0;
            r_rd_valid <= 1'b0;
            r_tx_done  <= 1'b0;
        end else begin
            r_rd_valid <= 1'b0;
            r_tx_done  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (op_host == OP_NONE) begin
                        r_armed <= 1'b1;
                    end
                    if (w_accept) begin
                        r_req  <= 1'b1;
                        r_wr   <= (op_host == OP_WR);
                        r_addr <= {AddrOut_host[31:6], 6'b0};
                        r_beat <= '0;
                        if (op_host == OP_WR) begin
                            r_wline <= DataOut_host;
                        end
                    end
                end
                S_BEAT: begin
                    if (mem.mem_ack) begin
                        if (!r_wr) begin
                            r_rdata[32'(r_beat) * WORD_BITS +: WORD_BITS] <= mem.mem_rdata;
                        end
                        r_wline <= {WORD_BITS'(0), r_wline[LINE_BITS-1:WORD_BITS]};
                        if (w_last) begin
                            r_req      <= 1'b0;
                            r_tx_done  <= 1'b1;
                            r_rd_valid <= !r_wr;
                        end else begin
                            r_beat <= r_beat + BEAT_W'(1);
                            r_addr <= r_addr + 32'(WORD_BYTES);
                        end
                    end
`ifdef HOST_RESP_TIMEOUT_EN
                    else if (w_timeout) begin
                        r_req     <= 1'b0;
                        r_tx_done <= 1'b1;
                    end
`endif
                end
                S_DONE: begin
                    r_armed <= 1'b0;
                end
                default: begin
                    r_req <= 1'b0;
                end
            endcase
        end
    end

    assign DataIn_host   = r_rdata;
    assign rd_valid_host = r_rd_valid;
    assign tx_done_host  = r_tx_done;
    assign mem.mem_req   = r_req;
    assign mem.mem_wr    = r_wr;
    assign mem.mem_addr  = r_addr;
    assign mem.mem_wdata = r_wline[WORD_BITS-1:0];
endmodule

// File: doc/host_line_responder.md
Name: host_line_responder

Overview:
- Responder end of the 512-bit host line interface that the fetch/mem_system initiators drive (op_host, AddrOut_host, DataOut_host in; DataIn_host, rd_valid_host, tx_done_host out).
- Accepts one line request at a time.
- Serialises the request into 16 word beats on a 32-bit request/acknowledge backing-memory port, then returns the assembled line or completes the write.
- Sits in the memory controller between the core-side caches and the word-wide memory.

Parameters:
- LINE_BITS, 512, host line width; fixed, must equal 16*WORD_BITS.
- WORD_BITS, 32, backing-memory word width.
- TIMEOUT_CYCLES, 255, per-beat acknowledge limit; used only with HOST_RESP_TIMEOUT_EN.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- op_host  input  2  request: 00 none, 01 read line, 10 write line, 11 reserved (ignored).
- AddrOut_host  input  32  request byte address; bits [5:0] ignored.
- DataOut_host  input  512  write line from the initiator; word i = bits [32i+31:32i].
- DataIn_host  output  512  read line to the initiator, same word packing.
- rd_valid_host  output  1  one-cycle pulse: DataIn_host holds a completed read.
- tx_done_host  output  1  one-cycle pulse: read or write transaction complete.
- mem_req  output  1  beat request, held until acknowledged.
- mem_wr  output  1  beat is a write; stable while mem_req is high.
- mem_addr  output  32  beat byte address; stable while mem_req is high.
- mem_wdata  output  32  write word; stable while mem_req is high.
- mem_ack  input  1  beat accepted this cycle; read data valid the same cycle.
- mem_rdata  input  32  read word, sampled when mem_req & mem_ack.
- err_host  output  1  timeout pulse; present only with HOST_RESP_TIMEOUT_EN.

Behaviour:
- Reset (async, rst_n low): state IDLE, armed=1, beat counter 0. All outputs 0, including DataIn_host.
- States:
  - IDLE: if armed and op_host is 01 or 10, latch base = {AddrOut_host[31:6], 6'b0}, latch the op and, for writes, DataOut_host. Clear beat to 0 and go to BEAT.
  - BEAT: mem_req=1, mem_addr = base + 4*beat, mem_wr = latched op is write, mem_wdata = latched word[beat].
    - On mem_ack during a read, capture mem_rdata into DataIn_host word[beat].
    - On mem_ack with beat<15: beat increments. mem_req stays high, so back-to-back beats are one per cycle with a zero-wait memory.
    - On mem_ack with beat==15: go to DONE.
    - No ack: hold every mem_* output unchanged.
  - DONE (one cycle): tx_done_host=1; rd_valid_host=1 only for reads. Clear armed, go to IDLE.
- Re-arm: armed is set whenever op_host==00 is sampled in IDLE. A request held high through tx_done is therefore not replayed; the initiator must drop op_host for at least one cycle.
- Ignored inputs:
  - op_host and AddrOut_host are ignored outside IDLE.
  - DataOut_host is used only at acceptance; later changes have no effect.
  - op 11 is ignored and does not clear armed.
- DataIn_host changes only during read beats and holds its value until the next read's beat captures, including across writes.
- Latency, zero-wait memory: request sampled at edge N → beats occupy cycles N+1..N+16 → tx_done in cycle N+17. Each wait cycle adds 1.
- Addresses never cross the 64-byte line; 32-bit addition with no wrap logic is needed because base[5:0]=0.
- Reset mid-transaction aborts immediately. No tx_done is issued and the partial DataIn_host is cleared.

Optional Feature:
- Macro HOST_RESP_TIMEOUT_EN.
- Defined: a per-beat wait counter resets on each ack. If it reaches TIMEOUT_CYCLES with no ack:
  - drop mem_req;
  - pulse err_host and tx_done_host together for one cycle, with rd_valid_host=0;
  - clear armed and return to IDLE;
  - DataIn_host keeps its partially updated contents.
- Undefined: no counter and no err_host port; the block waits indefinitely for mem_ack.

Test Plan:
- Read, zero-wait: op=01, addr 0x0000_1044, memory returns word = address → mem_addr runs 0x1040..0x107C over 16 consecutive cycles. tx_done and rd_valid pulse at N+17, and DataIn_host word i = 0x1040+4i.
- Write: op=10, addr 0x2000, DataOut_host word i = 0xA5000000+i, then DataOut_host changed after acceptance → 16 writes with mem_wdata 0xA5000000..0xA500000F. tx_done pulses once, rd_valid stays 0, DataIn_host is unchanged.
- Wait states: ack only every 3rd cycle on a read → mem_addr/mem_req held stable between acks, tx_done at N+1+48, data correct.
- Held request: op=01 held for 40 cycles → exactly one transaction. After dropping to 00 for one cycle and raising op=01 again, a second transaction starts.
- Reset at beat 7 of a read → all outputs 0 asynchronously, no tx_done. A subsequent read completes normally.
- With HOST_RESP_TIMEOUT_EN and TIMEOUT_CYCLES=8, mem_ack never asserted → err_host and tx_done pulse together, mem_req drops, and the block accepts the next request after op returns to 00.
